// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with private HI/LO registers for the EX stage
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MDU_MADD_EN is defined.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
`ifdef MDU_MADD_EN
    logic [63:0] r_acc;
`endif

    logic        w_idle;
    logic        w_issue;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_accept;
    logic        w_mthi;
    logic        w_mtlo;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic        w_b_nz;

    logic        w_res_we;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    // Issue qualification: flush kills only the instruction currently in EX.
    assign w_idle  = (r_state == S_IDLE);
    assign w_issue = start && !flush && w_idle;

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        case (mdop)
            OP_MULT, OP_MULTU: w_is_mul = 1'b1;
            OP_DIV, OP_DIVU:   w_is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_is_mul = 1'b1;
`endif
            default: begin
                w_is_mul = 1'b0;
                w_is_div = 1'b0;
            end
        endcase
    end

    assign w_accept = w_issue && (w_is_mul || w_is_div);
    assign w_mthi   = w_issue && (mdop == OP_MTHI);
    assign w_mtlo   = w_issue && (mdop == OP_MTLO);

    // Signed product from sign-extended operands: the low 64 bits of the unsigned
    // product of the extended values equal the two's complement signed product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide on magnitudes, then fix signs: quotient truncates toward zero,
    // remainder follows the dividend.
    assign w_a_neg = r_a[31];
    assign w_b_neg = r_b[31];
    assign w_abs_a = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_abs_b = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_b_nz  = (r_b != 32'd0);
    assign w_uq    = w_b_nz ? (w_abs_a / w_abs_b) : 32'd0;
    assign w_ur    = w_b_nz ? (w_abs_a % w_abs_b) : 32'd0;
    assign w_sq    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
    assign w_sr    = w_a_neg ? (32'd0 - w_ur) : w_ur;
    assign w_q_u   = w_b_nz ? (r_a / r_b) : 32'd0;
    assign w_r_u   = w_b_nz ? (r_a % r_b) : 32'd0;

    always_comb begin
        w_res_we = 1'b0;
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            OP_MULT: begin
                w_res_we = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_s;
            end
            OP_MULTU: begin
                w_res_we = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_u;
            end
            OP_DIV: begin
                w_res_we = w_b_nz;
                w_res_hi = w_sr;
                w_res_lo = w_sq;
            end
            OP_DIVU: begin
                w_res_we = w_b_nz;
                w_res_hi = w_r_u;
                w_res_lo = w_q_u;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                w_res_we = 1'b1;
                {w_res_hi, w_res_lo} = r_acc + w_prod_s;
            end
            OP_MADDU: begin
                w_res_we = 1'b1;
                {w_res_hi, w_res_lo} = r_acc + w_prod_u;
            end
            OP_MSUB: begin
                w_res_we = 1'b1;
                {w_res_hi, w_res_lo} = r_acc - w_prod_s;
            end
            OP_MSUBU: begin
                w_res_we = 1'b1;
                {w_res_hi, w_res_lo} = r_acc - w_prod_u;
            end
`endif
            default: begin
                w_res_we = 1'b0;
                w_res_hi = r_hi;
                w_res_lo = r_lo;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
`ifdef MDU_MADD_EN
            r_acc   <= 64'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= mdop;
                        r_cnt   <= w_is_div ? DIV_LOAD : MULT_LOAD;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
`ifdef MDU_MADD_EN
                        r_acc   <= {r_hi, r_lo};
`endif
                    end else if (w_mthi) begin
                        r_hi <= a;
                    end else if (w_mtlo) begin
                        r_lo <= a;
                    end
                end
                S_RUN: begin
                    // Counter reaching zero on this edge retires the operation.
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (w_res_we) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_comb begin
        rdata = 32'd0;
        if (mdop == OP_MFHI) begin
            rdata = r_hi;
        end else if (mdop == OP_MFLO) begin
            rdata = r_lo;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit: vector table, corner sequences, random vs model
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdop = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .flush(flush), .start(start), .mdop(mdop),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issues one instruction at posedge+1 and counts busy cycles after acceptance.
    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, output int cyc);
        start = 1'b1; mdop = op; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; mdop = 4'd0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    // Reference model: architectural effect of one op on m_hi/m_lo; returns busy length.
    function automatic int model(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        longint      ps;
        logic [63:0] pu;
        logic [63:0] acc;
        int          sa;
        int          sb;
        ps  = longint'($signed(va)) * longint'($signed(vb));
        pu  = {32'd0, va} * {32'd0, vb};
        acc = {m_hi, m_lo};
        sa  = va;
        sb  = vb;
        case (op)
            4'd1: begin {m_hi, m_lo} = ps; return MC; end
            4'd2: begin {m_hi, m_lo} = pu; return MC; end
            4'd3: begin
                if (vb != 0) begin m_lo = sa / sb; m_hi = sa % sb; end
                return DC;
            end
            4'd4: begin
                if (vb != 0) begin m_lo = va / vb; m_hi = va % vb; end
                return DC;
            end
            4'd7: begin m_hi = va; return 0; end
            4'd8: begin m_lo = va; return 0; end
            4'd9, 4'd10, 4'd11, 4'd12: begin
                if (!MADD_EN) return 0;
                if (op == 4'd9) {m_hi, m_lo} = acc + ps;
                else if (op == 4'd10) {m_hi, m_lo} = acc + pu;
                else if (op == 4'd11) {m_hi, m_lo} = acc - ps;
                else {m_hi, m_lo} = acc - pu;
                return MC;
            end
            default: return 0;
        endcase
    endfunction

    initial begin
        int cyc;
        int e;
        logic [3:0] ops [12];

        vecs[0] = '{4'd1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
        vecs[1] = '{4'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, MC};
        vecs[2] = '{4'd3, 32'h0, 32'h0, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{4'd4, 32'h0, 32'h0, 32'h7, 32'h2, 32'h1, 32'h3, DC};
        vecs[4] = '{4'd4, 32'h11111111, 32'h22222222, 32'h7, 32'h0, 32'h11111111, 32'h22222222, DC};
        vecs[5] = '{4'd3, 32'h0, 32'h0, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, DC};
        vecs[6] = '{4'd9, 32'h0, 32'h1, 32'h2, 32'h3, 32'h0, MADD_EN ? 32'h7 : 32'h1, MADD_EN ? MC : 0};
        vecs[7] = '{4'd12, 32'h0, 32'h7, 32'h8, 32'h1, MADD_EN ? 32'hFFFFFFFF : 32'h0,
                    MADD_EN ? 32'hFFFFFFFF : 32'h7, MADD_EN ? MC : 0};
        vecs[8] = '{4'd13, 32'h1, 32'h2, 32'h5, 32'h6, 32'h1, 32'h2, 0};
        vecs[9] = '{4'd5, 32'h3, 32'h4, 32'h5, 32'h6, 32'h3, 32'h4, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_rdata", {32'd0, rdata}, 64'd0);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op(4'd7, vecs[i].pre_hi, 32'd0, cyc);
            run_op(4'd8, vecs[i].pre_lo, 32'd0, cyc);
            run_op(vecs[i].op, vecs[i].va, vecs[i].vb, cyc);
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
        end

        // MTHI visible one cycle after accept; rdata follows mdop combinationally
        run_op(4'd8, 32'hCAFE0002, 32'd0, cyc);
        start = 1'b1; mdop = 4'd7; a = 32'hCAFE0001;
        #1;
        check("mthi_before_edge", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF & {32'd0, vecs[9].exp_hi});
        @(posedge clk); #1;
        start = 1'b0;
        check("mthi_after_edge", {32'd0, hi}, 64'h0000_0000_CAFE_0001);
        mdop = 4'd5; #1;
        check("rdata_mfhi", {32'd0, rdata}, 64'h0000_0000_CAFE_0001);
        mdop = 4'd6; #1;
        check("rdata_mflo", {32'd0, rdata}, 64'h0000_0000_CAFE_0002);
        mdop = 4'd7; #1;
        check("rdata_other", {32'd0, rdata}, 64'd0);
        mdop = 4'd0;

        // Flush in the issue cycle drops MULT and MTHI
        @(posedge clk); #1;
        flush = 1'b1; start = 1'b1; mdop = 4'd1; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        check("flush_mult_busy", {63'd0, busy}, 64'd0);
        mdop = 4'd7; a = 32'hDEAD0000;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; mdop = 4'd0;
        check("flush_mthi_hi", {32'd0, hi}, 64'h0000_0000_CAFE_0001);
        check("flush_mult_lo", {32'd0, lo}, 64'h0000_0000_CAFE_0002);

        // Flush after accept does not disturb the running op
        start = 1'b1; mdop = 4'd1; a = 32'hFFFFFFFF; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; mdop = 4'd0; flush = 1'b1;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        check("late_flush_cycles", 64'(cyc), 64'(MC));
        check("late_flush_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);

        // Start while busy is ignored, including a late MULTU
        start = 1'b1; mdop = 4'd4; a = 32'd7; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; mdop = 4'd0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            if (cyc == 3 || cyc == DC) begin
                start = 1'b1; mdop = 4'd2; a = 32'd3; b = 32'd3;
            end else begin
                start = 1'b0; mdop = 4'd0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mdop = 4'd0;
        check("busy_ignore_cycles", 64'(cyc), 64'(DC));
        check("busy_ignore_result", {hi, lo}, 64'h00000001_00000003);
        @(posedge clk); #1;
        check("busy_ignore_no_late_accept", {63'd0, busy}, 64'd0);

        // Back-to-back: issue in the cycle busy falls
        run_op(4'd2, 32'd6, 32'd7, cyc);
        run_op(4'd2, 32'd10, 32'd10, e);
        check("b2b_cycles", 64'(e), 64'(MC));
        check("b2b_result", {hi, lo}, 64'd100);

        // Reset in the middle of a divide
        start = 1'b1; mdop = 4'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; mdop = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_busy", {63'd0, busy}, 64'd0);
        check("reset_mid_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Randomized ops against the model
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd6};
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 50; i++) begin
            logic [3:0]  op;
            logic [31:0] ra;
            logic [31:0] rb;
            op = ops[$urandom_range(0, 11)];
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : 32'($urandom);
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            e = model(op, ra, rb);
            run_op(op, ra, rb, cyc);
            check($sformatf("rnd%0d_op%0d_cycles", i, op), 64'(cyc), 64'(e));
            check($sformatf("rnd%0d_op%0d_hi", i, op), {32'd0, hi}, {32'd0, m_hi});
            check($sformatf("rnd%0d_op%0d_lo", i, op), {32'd0, lo}, {32'd0, m_lo});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit in the EX stage of the five-stage pipeline. It consumes the forwarded rs/rt operands produced by the forwarding unit, runs multi-cycle multiply and divide operations into private HI/LO registers, and serves MFHI/MFLO reads back onto the EX result path. Its `busy` output feeds the stall controller, which holds MD-class instructions in ID while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles `busy` stays high for multiply-class ops; legal range 1..15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for divide ops; legal range 1..15.

Ports:
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  synchronous, active-high.
- `flush`  input  1  exception/interrupt flush of the EX instruction. Same-cycle `start` and MTHI/MTLO are dropped.
- `start`  input  1  EX instruction is a valid MD op; qualifies `mdop`.
- `mdop`  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU. Values 13–15 are treated as none.
- `a`  input  32  forwarded rs operand.
- `b`  input  32  forwarded rt operand.
- `busy`  output  1  an operation is in flight.
- `hi`  output  32  architectural HI register.
- `lo`  output  32  architectural LO register.
- `rdata`  output  32  combinational MF result: `hi` for MFHI, `lo` for MFLO, else 0.

## Operation
- Two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, with a 4-bit down-counter.
- An operation is accepted when `start`=1, `flush`=0, state IDLE, and `mdop` is in 1–4 or 9–12.
- On accept:
  - Latch `a`, `b` and `mdop`.
  - Load the counter with `MULT_CYCLES` (multiply-class ops) or `DIV_CYCLES` (DIV, DIVU).
  - Move to RUN.
- In RUN the counter decrements every cycle. On the edge where the counter reaches 0, HI/LO are written and the state returns to IDLE.
- Arithmetic:
  - MULT: {HI,LO} = signed 32×32 product, 64 bits.
  - MULTU: {HI,LO} = unsigned 32×32 product, 64 bits.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero and the remainder takes the dividend's sign.
  - MADD/MADDU: {HI,LO} += product, modulo 2^64.
  - MSUB/MSUBU: {HI,LO} −= product, modulo 2^64.
  - MADD/MSUB accumulate onto the {HI,LO} value latched at accept.
- Divide by zero: `busy` still runs the full `DIV_CYCLES`, and HI/LO are left unchanged.
- MTHI/MTLO: when `start`=1, `flush`=0 and state IDLE, `a` is written into HI or LO at that edge. There is no busy period.
- MFHI/MFLO: purely combinational read of the registered HI/LO. In-flight results are never bypassed.
- `start` while RUN: ignored entirely, including MTHI/MTLO. The stall controller must prevent this.
- `flush` has no effect on an operation already in RUN; that operation belongs to an older, committed instruction.
- Reset: state IDLE, counter 0, `busy`=0, `hi`=0, `lo`=0, `rdata`=0.
- Reset in RUN abandons the operation; HI/LO become 0.

## Timing
- An op accepted at edge T sets `busy`=1 for cycles T..T+N−1. HI/LO are valid and `busy`=0 after edge T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- Back-to-back: a new `start` in the cycle after `busy` falls is accepted.
- MTHI/MTLO writes are visible on `hi`/`lo` one cycle after the accept edge.
- `busy` is a register output. `rdata` has zero latency from `mdop`.

## Configuration
- `MDU_MADD_EN`:
  - Defined: mdop 9–12 perform the accumulate ops above, with `MULT_CYCLES` latency.
  - Undefined: mdop 9–12 are treated as none. There is no accept, no busy period, HI/LO are unchanged, and the accumulator adder is absent.

## Test plan
- MULT, a=0xFFFFFFFF, b=0x00000002 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV, a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, a=7, b=2 → LO=3, HI=1.
- Divide by zero:
  - Preload via MTHI a=0x11111111, then MTLO a=0x22222222.
  - DIVU with b=0 → `busy` high 10 cycles; HI/LO remain 0x11111111/0x22222222.
- `flush`=1 with MULT start → `busy` stays 0, HI/LO unchanged. MULT started, then `flush`=1 on the next cycle → operation completes normally.
- `start` MULTU asserted while `busy` → ignored; the first result is unaffected and `busy` drops on schedule. Reset asserted mid-DIV → next cycle `busy`=0, HI=LO=0.
- With `MDU_MADD_EN`: MTHI 0, MTLO 1, then MADD a=2, b=3 → LO=7, HI=0. MSUBU a=8, b=1 → {HI,LO}=0xFFFFFFFF_FFFFFFFF. Without the macro, the same MADD leaves LO=1 and `busy` never rises.
